// File: rtl/router_pkg.sv
// Shared constants for the router slice (FSM, synchroniser and per-destination FIFOs).
package router_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Header payload length occupies data[DATA_WIDTH-1:LEN_LSB]; low bits are the destination.
  localparam int LEN_LSB = 2;

  function automatic int tag_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// Read/write pointer pair with full/empty, fill level and threshold flags.
module router_fifo_ptr #(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          wr_acc,
  input  logic          rd_acc,
  output logic [AW:0]   wr_ptr,
  output logic [AW:0]   rd_ptr,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_THRESH);

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty        = (wr_ptr == rd_ptr);
  assign level        = wr_ptr - rd_ptr;
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware per-destination FIFO: header-tagged storage, registered read port,
// remaining-word counter and end-of-packet flag.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter int LFD_DELAY  = 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int PW        = DATA_WIDTH - 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  pkt_end,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           level,
  output logic [PW-1:0]         pkt_remaining
);

  localparam int TAG = tag_bit(DATA_WIDTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                clear;
  logic                wr_acc;
  logic                rd_acc;
  logic                lfd_q;
  logic                tag;
  logic [DATA_WIDTH:0] rd_word;
  logic [PW-1:0]       hdr_len;

  assign clear  = reset || soft_reset;
  assign wr_acc = write_enb && !full && !clear;
  assign rd_acc = read_enb && !empty && !clear;

  router_fifo_ptr #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ptr (
    .clock        (clock),
    .clear        (clear),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level)
  );

  // The FSM raises lfd_state in the cycle before the header write when LFD_DELAY is set.
  always_ff @(posedge clock) begin
    if (clear) lfd_q <= 1'b0;
    else       lfd_q <= lfd_state;
  end

  assign tag = (LFD_DELAY != 0) ? lfd_q : lfd_state;

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= {tag, data_in};
  end

  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign hdr_len = PW'(rd_word[DATA_WIDTH-1:LEN_LSB]);

  always_ff @(posedge clock) begin
    if (clear) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      pkt_end       <= 1'b0;
      pkt_remaining <= '0;
    end else if (rd_acc) begin
      data_out   <= rd_word[DATA_WIDTH-1:0];
      data_valid <= 1'b1;
      if (rd_word[TAG]) begin
        // Payload words plus the trailing parity word.
        pkt_remaining <= hdr_len + PW'(1);
        pkt_end       <= 1'b0;
      end else if (pkt_remaining != '0) begin
        pkt_remaining <= pkt_remaining - PW'(1);
        pkt_end       <= (pkt_remaining == PW'(1));
      end else begin
        pkt_end <= 1'b0;
      end
    end else begin
      data_valid <= 1'b0;
      pkt_end    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed self-checking bench for router_fifo_pkt: default build, a same-cycle lfd build
// and a 16-bit x 64-entry build.
module tb_router_fifo_pkt;

  logic clock = 1'b0;
  logic reset;
  logic soft_reset;

  logic       write_enb, lfd_state, read_enb;
  logic [7:0] data_in, data_out;
  logic       data_valid, pkt_end, empty, full, almost_full, almost_empty;
  logic [4:0] level;
  logic [6:0] pkt_remaining;

  logic       d0_write_enb, d0_lfd_state, d0_read_enb;
  logic [7:0] d0_data_in, d0_data_out;
  logic       d0_data_valid, d0_pkt_end, d0_empty, d0_full, d0_almost_full, d0_almost_empty;
  logic [4:0] d0_level;
  logic [6:0] d0_pkt_remaining;

  logic        w_write_enb, w_lfd_state, w_read_enb;
  logic [15:0] w_data_in, w_data_out;
  logic        w_data_valid, w_pkt_end, w_empty, w_full, w_almost_full, w_almost_empty;
  logic [6:0]  w_level;
  logic [14:0] w_pkt_remaining;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  router_fifo_pkt u_dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
    .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
    .data_valid(data_valid), .pkt_end(pkt_end), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .pkt_remaining(pkt_remaining)
  );

  router_fifo_pkt #(.LFD_DELAY(0)) u_d0 (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(d0_write_enb),
    .lfd_state(d0_lfd_state), .data_in(d0_data_in), .read_enb(d0_read_enb),
    .data_out(d0_data_out), .data_valid(d0_data_valid), .pkt_end(d0_pkt_end),
    .empty(d0_empty), .full(d0_full), .almost_full(d0_almost_full),
    .almost_empty(d0_almost_empty), .level(d0_level), .pkt_remaining(d0_pkt_remaining)
  );

  router_fifo_pkt #(.DATA_WIDTH(16), .DEPTH(64), .AF_THRESH(62), .AE_THRESH(2)) u_w (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(w_write_enb),
    .lfd_state(w_lfd_state), .data_in(w_data_in), .read_enb(w_read_enb),
    .data_out(w_data_out), .data_valid(w_data_valid), .pkt_end(w_pkt_end),
    .empty(w_empty), .full(w_full), .almost_full(w_almost_full),
    .almost_empty(w_almost_empty), .level(w_level), .pkt_remaining(w_pkt_remaining)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_d [5];
    logic [6:0] exp_r [5];
    exp_d = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_r = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};

    reset = 1'b1; soft_reset = 1'b0;
    write_enb = 0; lfd_state = 0; read_enb = 0; data_in = '0;
    d0_write_enb = 0; d0_lfd_state = 0; d0_read_enb = 0; d0_data_in = '0;
    w_write_enb = 0; w_lfd_state = 0; w_read_enb = 0; w_data_in = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_level", level, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_pend", pkt_end, 0);
    chk("rst_prem", pkt_remaining, 0);
    chk("rst_dout", data_out, 0);

    // Packet: header 0x0D (len 3) + 3 payload + parity, tag from previous-cycle lfd.
    lfd_state = 1; tick();
    lfd_state = 0; write_enb = 1;
    for (int i = 0; i < 5; i++) begin
      data_in = exp_d[i]; tick();
    end
    write_enb = 0;
    chk("t1_level", level, 5);
    chk("t1_ae", almost_empty, 0);
    read_enb = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_dout", data_out, exp_d[i]);
      chk("t1_valid", data_valid, 1);
      chk("t1_prem", pkt_remaining, exp_r[i]);
      chk("t1_pend", pkt_end, (i == 4) ? 1 : 0);
    end
    read_enb = 0;
    chk("t1_empty", empty, 1);
    tick();
    chk("t1_idle_valid", data_valid, 0);
    chk("t1_idle_pend", pkt_end, 0);
    chk("t1_idle_hold", data_out, 8'h44);

    // Fill to full, drop overflow (also while a read happens), drain in order.
    write_enb = 1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'hA0 + 8'(i); tick();
      chk("t2_level", level, i + 1);
      chk("t2_af", almost_full, (i + 1 >= 14) ? 1 : 0);
      chk("t2_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
    end
    chk("t2_full", full, 1);
    data_in = 8'hFF; tick();
    chk("t2_drop_level", level, 16);
    data_in = 8'hEE; read_enb = 1; tick();
    write_enb = 0;
    chk("t2_rw_full_level", level, 15);
    chk("t2_first", data_out, 8'hA0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("t2_dout", data_out, 8'hA0 + 8'(i));
      chk("t2_prem", pkt_remaining, 0);
      chk("t2_pend", pkt_end, 0);
    end
    read_enb = 0;
    chk("t2_empty", empty, 1);
    tick();
    chk("t2_idle_valid", data_valid, 0);

    // Level 8 held through 20 simultaneous read/write cycles across pointer wrap.
    write_enb = 1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'h50 + 8'(i); tick();
    end
    chk("t3_level0", level, 8);
    read_enb = 1;
    for (int k = 0; k < 20; k++) begin
      data_in = 8'h60 + 8'(k); tick();
      chk("t3_level", level, 8);
      chk("t3_dout", data_out, (k < 8) ? 8'h50 + 8'(k) : 8'h60 + 8'(k - 8));
    end
    write_enb = 0; read_enb = 0;
    soft_reset = 1; tick(); soft_reset = 0;
    chk("t3_flush_level", level, 0);

    // Soft reset mid-packet, then a fresh packet.
    lfd_state = 1; tick();
    lfd_state = 0; write_enb = 1;
    data_in = 8'h09; tick();
    data_in = 8'h71; tick();
    data_in = 8'h72; tick();
    data_in = 8'h73; tick();
    write_enb = 0; read_enb = 1;
    tick();
    chk("t4_hdr_prem", pkt_remaining, 3);
    tick();
    chk("t4_pay_prem", pkt_remaining, 2);
    read_enb = 0; soft_reset = 1; tick(); soft_reset = 0;
    chk("t4_level", level, 0);
    chk("t4_valid", data_valid, 0);
    chk("t4_prem", pkt_remaining, 0);
    chk("t4_empty", empty, 1);
    chk("t4_dout", data_out, 0);
    lfd_state = 1; tick();
    lfd_state = 0; write_enb = 1;
    data_in = 8'h05; tick();
    data_in = 8'h81; tick();
    data_in = 8'h82; tick();
    write_enb = 0; read_enb = 1;
    tick();
    chk("t4_new_hdr", data_out, 8'h05);
    chk("t4_new_prem0", pkt_remaining, 2);
    tick();
    chk("t4_new_prem1", pkt_remaining, 1);
    chk("t4_new_pend1", pkt_end, 0);
    tick();
    chk("t4_new_prem2", pkt_remaining, 0);
    chk("t4_new_pend2", pkt_end, 1);
    read_enb = 0;

    // Zero-length header, registered-lfd build.
    lfd_state = 1; tick();
    lfd_state = 0; write_enb = 1;
    data_in = 8'h03; tick();
    data_in = 8'h55; tick();
    write_enb = 0; read_enb = 1;
    tick();
    chk("t5_hdr_prem", pkt_remaining, 1);
    chk("t5_hdr_pend", pkt_end, 0);
    tick();
    chk("t5_par_pend", pkt_end, 1);
    chk("t5_par_prem", pkt_remaining, 0);
    chk("t5_par_dout", data_out, 8'h55);
    read_enb = 0;

    // Zero-length header, same-cycle-lfd build.
    d0_lfd_state = 1; d0_write_enb = 1; d0_data_in = 8'h03; tick();
    d0_lfd_state = 0; d0_data_in = 8'hAA; tick();
    d0_write_enb = 0; d0_read_enb = 1;
    tick();
    chk("t5d0_hdr_prem", d0_pkt_remaining, 1);
    chk("t5d0_hdr_pend", d0_pkt_end, 0);
    tick();
    chk("t5d0_par_pend", d0_pkt_end, 1);
    chk("t5d0_par_dout", d0_data_out, 8'hAA);
    d0_read_enb = 0;

    // Wide/deep build: fill to 64, long header length.
    w_lfd_state = 1; tick();
    w_lfd_state = 0; w_write_enb = 1;
    w_data_in = 16'h0FA0; tick();
    for (int i = 1; i < 64; i++) begin
      w_data_in = 16'(i); tick();
    end
    chk("t6_level", w_level, 64);
    chk("t6_full", w_full, 1);
    chk("t6_af", w_almost_full, 1);
    w_data_in = 16'hFFFF; tick();
    chk("t6_drop_level", w_level, 64);
    w_write_enb = 0; w_read_enb = 1;
    tick();
    w_read_enb = 0;
    chk("t6_prem", w_pkt_remaining, 1001);
    chk("t6_dout", w_data_out, 16'h0FA0);
    chk("t6_level_after", w_level, 63);
    chk("t6_notfull", w_full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
